// File: rtl/sha256_pkg.sv
// Shared constants and helpers for the SHA-256 message-schedule datapath.
package sha256_pkg;

  localparam int WORD_W = 32;
  localparam int WIN_LEN = 16;
  localparam int IDX_W = 6;
  localparam int CNT_W = 4;

  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR = 3;
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR = 10;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/sigma0.sv
// Small sigma0 of the SHA-256 schedule: rotr7 ^ rotr18 ^ shr3.
module sigma0
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  assign y = rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);

endmodule

// File: rtl/sigma1.sv
// Small sigma1 of the SHA-256 schedule: rotr17 ^ rotr19 ^ shr10.
module sigma1
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  assign y = rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);

endmodule

// File: rtl/sha256_msg_sched.sv
// Loads one 16-word message block into a sliding window, then streams
// W[0]..W[N_ROUNDS-1], generating each new word from the window.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int N_ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [IDX_W-1:0]  w_idx,
  output logic              busy,
  output logic              done
);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   load_cnt_q;
  logic [IDX_W-1:0]   t_q;
  logic               done_q;
  word_t              win_q [WIN_LEN];

  logic  in_fire;
  logic  w_fire;
  logic  last_load;
  logic  last_word;
  word_t s0_out;
  word_t s1_out;
  word_t gen_word;
  word_t fill_word;

  assign in_fire   = (state_q == ST_LOAD) && in_valid;
  assign w_fire    = (state_q == ST_RUN) && w_ready;
  assign last_load = (load_cnt_q == CNT_W'(WIN_LEN - 1));
  assign last_word = (t_q == IDX_W'(N_ROUNDS - 1));

  sigma0 u_sigma0 (
    .x (win_q[1]),
    .y (s0_out)
  );

  sigma1 u_sigma1 (
    .x (win_q[14]),
    .y (s1_out)
  );

  // W[t+16] relative to a window whose oldest entry is W[t]; wraps mod 2^32.
  assign gen_word  = s1_out + win_q[9] + s0_out + win_q[0];
  assign fill_word = (state_q == ST_LOAD) ? in_data : gen_word;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: if (in_fire && last_load) state_d = ST_RUN;
      ST_RUN:  if (w_fire && last_word) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // One shift register serves both the external fill and the generated fill.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < WIN_LEN; i++) begin
        win_q[i] <= '0;
      end
    end else if (in_fire || w_fire) begin
      for (int i = 0; i < WIN_LEN - 1; i++) begin
        win_q[i] <= win_q[i+1];
      end
      win_q[WIN_LEN-1] <= fill_word;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      load_cnt_q <= '0;
      t_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= w_fire && last_word;
      if ((state_q == ST_IDLE) && start) begin
        load_cnt_q <= '0;
      end else if (in_fire) begin
        load_cnt_q <= load_cnt_q + 1'b1;
      end
      if (in_fire && last_load) begin
        t_q <= '0;
      end else if (w_fire) begin
        t_q <= t_q + 1'b1;
      end
    end
  end

  assign in_ready = (state_q == ST_LOAD);
  assign w_valid  = (state_q == ST_RUN);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign w_data   = w_valid ? win_q[0] : '0;
  assign w_idx    = w_valid ? t_q : '0;

endmodule
